// File: rtl/cone_sweep_if.sv
// cone_sweep_if: sweep control handshake, cone vector and checker results
interface cone_sweep_if #(parameter int N_IN = 5, parameter int CNT_W = 8);
  logic start;
  logic abort;
  logic golden_i;
  logic faulty_i;
  logic [N_IN-1:0] vec_o;
  logic busy;
  logic done;
  logic [CNT_W-1:0] err_cnt;
  logic err_flag;
  logic [N_IN-1:0] first_err_vec;
  logic first_err_valid;
  modport master (output start, abort, golden_i, faulty_i,
                  input vec_o, busy, done, err_cnt, err_flag, first_err_vec, first_err_valid);
  modport slave (input start, abort, golden_i, faulty_i,
                 output vec_o, busy, done, err_cnt, err_flag, first_err_vec, first_err_valid);
endinterface

// File: rtl/cone_sweep_checker.sv
// cone_sweep_checker: exhaustive input sweep of a cone comparing golden and fault-injected outputs
module cone_sweep_checker #(
  parameter int N_IN = 5,
  parameter int SETTLE = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  cone_sweep_if.slave bus
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] LAST = SW'(SETTLE - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;
  state_t r_state;
  logic [SW-1:0] r_settle;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] r_first_vec;
  logic [CNT_W-1:0] r_cnt;
  logic r_busy;
  logic r_done;
  logic r_flag;
  logic r_first_valid;
  logic w_mis;
  assign w_mis = bus.golden_i ^ bus.faulty_i;
  // Sweep FSM; busy and done are registered alongside the state so no input reaches an output combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_settle <= '0;
      r_vec <= '0;
      r_first_vec <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_flag <= 1'b0;
      r_first_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_vec <= '0;
          r_cnt <= '0;
          r_flag <= 1'b0;
          r_first_vec <= '0;
          r_first_valid <= 1'b0;
          r_settle <= '0;
          r_busy <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: if (bus.abort) begin
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_settle <= r_settle + 1'b1;
          r_state <= r_settle == LAST ? S_SAMPLE : S_WAIT;
        end
        S_SAMPLE: if (bus.abort) begin
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          if (w_mis) begin
            r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
            r_flag <= 1'b1;
            if (!r_first_valid) begin
              r_first_vec <= r_vec;
              r_first_valid <= 1'b1;
            end
          end
          if (&r_vec) begin
            r_busy <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_vec <= r_vec + 1'b1;
            r_settle <= '0;
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_done <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign bus.vec_o = r_vec;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err_cnt = r_cnt;
  assign bus.err_flag = r_flag;
  assign bus.first_err_vec = r_first_vec;
  assign bus.first_err_valid = r_first_valid;
endmodule

// File: doc/cone_sweep_checker.md
Name: cone_sweep_checker

Overview:
- Drives the complete input space of an N_IN-input combinational cone and checks the cone's outputs.
- Samples two copies of the cone output: golden and fault-injected.
- Counts input vectors where the two outputs differ (SEE error propagation) and records the first failing vector.
- Sits between the SEE analysis controller (start/done handshake) and the cone instances under test.

Parameters:
N_IN, 5, width of the cone input vector; 2^N_IN vectors are swept
SETTLE, 1, cycles each vector is held before sampling (must be >= 1)
CNT_W, 8, width of the mismatch counter (saturating)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a sweep; honoured only in IDLE
abort  input  1  terminate a sweep in progress
vec_o  output  N_IN  vector driven to the cone inputs of both copies
golden_i  input  1  output of the fault-free cone
faulty_i  input  1  output of the fault-injected cone
busy  output  1  high in WAIT and SAMPLE
done  output  1  one-cycle pulse when a sweep completes normally
err_cnt  output  CNT_W  count of mismatching vectors, saturates at all-ones
err_flag  output  1  sticky: at least one mismatch in the current/last sweep
first_err_vec  output  N_IN  vector of the first mismatch
first_err_valid  output  1  first_err_vec holds a captured value

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) takes priority over all other inputs, including mid-sweep.
  - Next cycle: state=IDLE, vec_o=0, busy=0, done=0, err_cnt=0, err_flag=0, first_err_vec=0, first_err_valid=0, settle counter=0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start=1:
  - Clear vec_o, err_cnt, err_flag, first_err_valid and first_err_vec.
  - Load settle counter with 0 and go to WAIT.
  - start=0 keeps IDLE; all results hold.
- WAIT:
  - vec_o is stable; settle counter increments each cycle.
  - After SETTLE cycles in WAIT, go to SAMPLE.
- SAMPLE, single cycle; mismatch = golden_i XOR faulty_i, registered on the edge leaving SAMPLE.
  - If mismatch: err_cnt+1, saturating at 2^CNT_W-1; err_flag=1.
  - If mismatch and first_err_valid=0: first_err_vec=vec_o and first_err_valid=1.
  - If vec_o is all-ones: go to DONE with vec_o held.
  - Otherwise: vec_o+1, settle counter=0, go to WAIT.
- DONE, single cycle: done=1, busy=0; next state IDLE.
- Timing:
  - Each vector costs SETTLE+1 cycles.
  - done is high exactly 2^N_IN*(SETTLE+1)+1 cycles after the edge that captured start (65 for the defaults).
- Holding after completion: vec_o, err_cnt, err_flag and first_err_* hold until the next accepted start or rst.
- start while busy or in DONE: ignored; no restart, no clear.
- abort=1 in WAIT or SAMPLE:
  - Next state IDLE; no done pulse.
  - The abort cycle's SAMPLE compare is discarded.
  - vec_o and all results hold their values at the abort.
- Simultaneous abort and start in IDLE: start wins; abort has no effect in IDLE or DONE.
- golden_i and faulty_i are sampled only in SAMPLE; their values in other states are don't-care.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Defaults, faulty_i tied to golden_i, pulse start -> busy for 64 cycles, done pulse at cycle 65, err_cnt=0, err_flag=0, first_err_valid=0, vec_o=5'h1F.
2. Defaults, faulty_i = golden_i XOR (vec_o==5'h0A || vec_o==5'h13) -> err_cnt=2, err_flag=1, first_err_vec=5'h0A, first_err_valid=1.
3. CNT_W=3, faulty_i = NOT golden_i for all vectors -> err_cnt saturates at 7 and stays there, done at cycle 65.
4. SETTLE=3, abort asserted on cycle 20 after start -> returns to IDLE, no done pulse, busy=0 next cycle; a fresh start clears err_cnt and sweeps to done at cycle 129.
5. rst asserted mid-sweep (cycle 30) together with start -> all outputs zero the next cycle, state IDLE; start re-pulsed after rst released -> a full sweep completes normally.
6. start held high through the whole sweep and through DONE -> exactly one sweep runs before DONE; a second sweep begins the cycle after returning to IDLE (start still high), with err_cnt cleared.
